ppu_vram_arb: RTL

PPU_VRAM_ARB -- requirements
Module: ppu_vram_arb

---
 rtl/ppu_vram_arb_pkg.sv | 13 +
 rtl/ppu_vram_arb_ri_fsm.sv | 67 ++++++
 rtl/ppu_vram_arb.sv | 84 ++++++++
 3 files changed

// File: rtl/ppu_vram_arb_pkg.sv
// Shared constants and ri access FSM state encoding for the PPU VRAM arbiter.
package ppu_vram_arb_pkg;
  localparam int unsigned VRAM_AW = 14;
  localparam int unsigned VRAM_DW = 8;
  localparam int unsigned WAIT_W  = 8;

  typedef enum logic [1:0] {
    RI_IDLE,
    RI_PEND,
    RI_ACCESS,
    RI_DONE
  } ri_state_t;
endpackage

// File: rtl/ppu_vram_arb_ri_fsm.sv
// Register-interface (0x2007) access sequencer: latches one request, waits for a
// free bus or starvation limit, performs a single VRAM access, then acknowledges.
module ppu_vram_arb_ri_fsm
  import ppu_vram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic               req,
  input  logic               wr,
  input  logic [VRAM_AW-1:0] addr,
  input  logic [VRAM_DW-1:0] wdata,
  input  logic [VRAM_DW-1:0] rdata_bus,
  output ri_state_t          state,
  output logic               wr_q,
  output logic [VRAM_AW-1:0] addr_q,
  output logic [VRAM_DW-1:0] wdata_q,
  output logic [VRAM_DW-1:0] rdata_q
);

  localparam logic [WAIT_W-1:0] LIMIT_M1 = WAIT_W'(STARVE_LIMIT - 1);

  ri_state_t         state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;

  // With no fetch contending, IDLE goes straight to ACCESS so an uncontended
  // request completes one cycle after it is seen.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RI_IDLE:   if (req) state_nxt = fetch_req ? RI_PEND : RI_ACCESS;
      RI_PEND: begin
        if (!fetch_req || wait_cnt >= LIMIT_M1) state_nxt = RI_ACCESS;
        else if (wait_cnt != '1)                wait_nxt  = wait_cnt + 1'b1;
      end
      RI_ACCESS: state_nxt = RI_DONE;
      RI_DONE:   state_nxt = RI_IDLE;
      default:   state_nxt = RI_IDLE;
    endcase
    if (state_nxt == RI_ACCESS) wait_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RI_IDLE;
      wait_cnt <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state == RI_IDLE && req) begin
        wr_q    <= wr;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state == RI_ACCESS && !wr_q) rdata_q <= rdata_bus;
    end
  end

endmodule

// File: rtl/ppu_vram_arb.sv
// PPU VRAM arbiter: background/sprite fetches and the CPU register port share one bus.
// Optional PPU_VRAM_ARB_STALL_CNT_EN adds a saturating count of contended PEND cycles.
module ppu_vram_arb
  import ppu_vram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               bg_req_in,
  input  logic [VRAM_AW-1:0] bg_a_in,
  input  logic               spr_req_in,
  input  logic [VRAM_AW-1:0] spr_a_in,
  input  logic               ri_req_in,
  input  logic               ri_wr_in,
  input  logic [VRAM_AW-1:0] ri_a_in,
  input  logic [VRAM_DW-1:0] ri_d_in,
  input  logic [VRAM_DW-1:0] vram_d_in,
  output logic [VRAM_AW-1:0] vram_a_out,
  output logic [VRAM_DW-1:0] vram_d_out,
  output logic               vram_wr_out,
  output logic               bg_gnt_out,
  output logic               spr_gnt_out,
  output logic               ri_busy_out,
  output logic               ri_ack_out,
  output logic [VRAM_DW-1:0] ri_d_out
`ifdef PPU_VRAM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt_out
`endif
);

  ri_state_t          ri_state;
  logic               ri_wr_q;
  logic [VRAM_AW-1:0] ri_a_q;
  logic [VRAM_DW-1:0] ri_wd_q;
  logic               ri_own;

  ppu_vram_arb_ri_fsm #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_ri_fsm (
    .clk      (clk_in),
    .rst      (rst_in),
    .fetch_req(bg_req_in | spr_req_in),
    .req      (ri_req_in),
    .wr       (ri_wr_in),
    .addr     (ri_a_in),
    .wdata    (ri_d_in),
    .rdata_bus(vram_d_in),
    .state    (ri_state),
    .wr_q     (ri_wr_q),
    .addr_q   (ri_a_q),
    .wdata_q  (ri_wd_q),
    .rdata_q  (ri_d_out)
  );

  // ACCESS always owns the bus: it is entered either because fetches were idle
  // or because the starvation limit forced it, and the strobe must not collide.
  assign ri_own = (ri_state == RI_ACCESS);

  always_comb begin
    bg_gnt_out  = bg_req_in & ~ri_own;
    spr_gnt_out = spr_req_in & ~bg_req_in & ~ri_own;
    if (ri_own)           vram_a_out = ri_a_q;
    else if (bg_gnt_out)  vram_a_out = bg_a_in;
    else if (spr_gnt_out) vram_a_out = spr_a_in;
    else                  vram_a_out = ri_a_q;
  end

  assign vram_d_out  = ri_wd_q;
  assign vram_wr_out = ri_own & ri_wr_q;
  assign ri_busy_out = (ri_state != RI_IDLE);
  assign ri_ack_out  = (ri_state == RI_DONE);

`ifdef PPU_VRAM_ARB_STALL_CNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      stall_cnt_out <= '0;
    else if (ri_state == RI_PEND && (bg_req_in | spr_req_in) && stall_cnt_out != '1)
      stall_cnt_out <= stall_cnt_out + 16'd1;
  end
`endif

endmodule
